// File: rtl/prf_debug_ctrl.sv
// prf_debug_ctrl: byte-serial debug access sequencer for the physical register file debug port.
module prf_debug_ctrl #(
  parameter int PHYS_LOG = 7,
  parameter int DATA_W   = 64,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                quiesce_i,
  input  logic                cmdValid_i,
  output logic                cmdReady_o,
  input  logic                cmdWrite_i,
  input  logic [PHYS_LOG-1:0] cmdAddr_i,
  input  logic                byteValid_i,
  input  logic [7:0]          byteData_i,
  output logic                byteReady_o,
  output logic                rdByteValid_o,
  output logic [7:0]          rdByteData_o,
  input  logic                rdByteReady_i,
  output logic [PHYS_LOG-1:0] prfAddr_o,
  output logic [DATA_W-1:0]   prfWrData_o,
  output logic                prfWrEn_o,
  input  logic [DATA_W-1:0]   prfRdData_i,
  output logic                busy_o,
  output logic                err_o
);
  localparam int NBYTES = DATA_W / 8;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  localparam logic [1:0] LAT = 2'(RD_LAT);
  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_COMMIT, RD_WAIT, RD_SEND} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] lat_q, lat_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [PHYS_LOG-1:0] addr_q, addr_d;
  logic err_q, err_d;
  assign cmdReady_o = (state_q == IDLE) & quiesce_i;
  assign byteReady_o = state_q == WR_COLLECT;
  assign prfWrEn_o = (state_q == WR_COMMIT) & quiesce_i;
  assign rdByteValid_o = state_q == RD_SEND;
  assign rdByteData_o = word_q[{cnt_q, 3'b000} +: 8];
  assign prfAddr_o = addr_q;
  assign prfWrData_o = word_q;
  assign busy_o = state_q != IDLE;
  assign err_o = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    word_d = word_q;
    addr_d = addr_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (cmdValid_i && cmdReady_o) begin
        addr_d = cmdAddr_i;
        cnt_d = '0;
        lat_d = '0;
        state_d = cmdWrite_i ? WR_COLLECT : RD_WAIT;
      end
      WR_COLLECT: if (byteValid_i) begin
        word_d[{cnt_q, 3'b000} +: 8] = byteData_i;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == LAST ? WR_COMMIT : WR_COLLECT;
      end
      WR_COMMIT: state_d = IDLE;
      RD_WAIT: if (lat_q == LAT) begin
        word_d = prfRdData_i;
        cnt_d = '0;
        state_d = RD_SEND;
      end else lat_d = lat_q + 2'd1;
      RD_SEND: if (rdByteReady_i) begin
        cnt_d = cnt_q == LAST ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == LAST ? IDLE : RD_SEND;
      end
      default: state_d = IDLE;
    endcase
    // losing quiesce anywhere outside IDLE drops the access; any in-flight byte goes with it
    if (state_q != IDLE && !quiesce_i) begin
      state_d = IDLE;
      cnt_d = '0;
      word_d = word_q;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lat_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      word_q <= word_d;
      addr_q <= addr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_prf_debug_ctrl.sv
// tb_prf_debug_ctrl: randomized bench against a register-file model of the debug access sequencer.
module tb_prf_debug_ctrl;
  localparam int PL = 7, DW = 64, NB = DW / 8;
  logic clk = 1'b0, reset = 1'b1, quiesce_i = 1'b0;
  logic cmdValid_i = 1'b0, cmdWrite_i = 1'b0;
  logic [PL-1:0] cmdAddr_i = '0;
  logic byteValid_i = 1'b0;
  logic [7:0] byteData_i = '0;
  logic rdByteReady_i = 1'b0;
  logic cmdReady_o, byteReady_o, rdByteValid_o, prfWrEn_o, busy_o, err_o;
  logic [7:0] rdByteData_o;
  logic [PL-1:0] prfAddr_o;
  logic [DW-1:0] prfWrData_o, prfRdData_i;
  logic [DW-1:0] prf_mem [128];
  logic [DW-1:0] exp_mem [128];
  int total = 0, bad = 0, wr_cnt = 0;

  prf_debug_ctrl #(.PHYS_LOG(PL), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .quiesce_i(quiesce_i),
    .cmdValid_i(cmdValid_i), .cmdReady_o(cmdReady_o), .cmdWrite_i(cmdWrite_i), .cmdAddr_i(cmdAddr_i),
    .byteValid_i(byteValid_i), .byteData_i(byteData_i), .byteReady_o(byteReady_o),
    .rdByteValid_o(rdByteValid_o), .rdByteData_o(rdByteData_o), .rdByteReady_i(rdByteReady_i),
    .prfAddr_o(prfAddr_o), .prfWrData_o(prfWrData_o), .prfWrEn_o(prfWrEn_o), .prfRdData_i(prfRdData_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  assign prfRdData_i = prf_mem[prfAddr_o];

  // the register file itself: absorbs every write pulse the controller issues
  always begin
    @(negedge clk);
    #3;
    if (prfWrEn_o) begin
      wr_cnt++;
      prf_mem[prfAddr_o] = prfWrData_o;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (rdByteValid_o !== 1'b0) begin bad++; $display("FAIL reset_rdvalid got=%b exp=0", rdByteValid_o); end
    total++; if (prfWrEn_o !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", prfWrEn_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    total++; if (byteReady_o !== 1'b0) begin bad++; $display("FAIL reset_byteready got=%b exp=0", byteReady_o); end
    total++; if (prfAddr_o !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", prfAddr_o); end
    total++; if (prfWrData_o !== '0) begin bad++; $display("FAIL reset_wrdata got=%h exp=0", prfWrData_o); end
    total++; if (rdByteData_o !== '0) begin bad++; $display("FAIL reset_rddata got=%h exp=0", rdByteData_o); end
    total++; if (cmdReady_o !== 1'b0) begin bad++; $display("FAIL reset_cmdready_noq got=%b exp=0", cmdReady_o); end
    reset = 1'b0;
    quiesce_i = 1'b1;
    #1;
    total++; if (cmdReady_o !== 1'b1) begin bad++; $display("FAIL idle_cmdready got=%b exp=1", cmdReady_o); end
  endtask

  task automatic do_write(input logic [PL-1:0] a, input logic [DW-1:0] d);
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    cmdValid_i = 1'b1; cmdWrite_i = 1'b1; cmdAddr_i = a;
    #1;
    total++; if (cmdReady_o !== 1'b1) begin bad++; $display("FAIL wr_cmdready got=%b exp=1", cmdReady_o); end
    @(negedge clk);
    cmdValid_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      byteValid_i = 1'b1; byteData_i = d[8*i +: 8];
      #1;
      total++; if (byteReady_o !== 1'b1) begin bad++; $display("FAIL wr_byteready[%0d] got=%b exp=1", i, byteReady_o); end
      @(negedge clk);
      byteValid_i = 1'b0;
    end
    #1;
    total++; if (prfWrEn_o !== 1'b1) begin bad++; $display("FAIL wr_commit_en got=%b exp=1", prfWrEn_o); end
    total++; if (prfAddr_o !== a) begin bad++; $display("FAIL wr_addr got=%h exp=%h", prfAddr_o, a); end
    total++; if (prfWrData_o !== d) begin bad++; $display("FAIL wr_data got=%h exp=%h", prfWrData_o, d); end
    @(negedge clk);
    #1;
    total++; if (wr_cnt !== w0 + 1) begin bad++; $display("FAIL wr_pulses got=%0d exp=%0d", wr_cnt - w0, 1); end
    total++; if (cmdReady_o !== 1'b1) begin bad++; $display("FAIL wr_back_idle got=%b exp=1", cmdReady_o); end
    exp_mem[a] = d;
  endtask

  task automatic do_read(input logic [PL-1:0] a, input bit bp);
    int n, cyc;
    bit pend;
    logic [7:0] held;
    logic [DW-1:0] e;
    e = exp_mem[a];
    n = 0; cyc = 0; pend = 1'b0; held = '0;
    @(negedge clk);
    cmdValid_i = 1'b1; cmdWrite_i = 1'b0; cmdAddr_i = a;
    #1;
    total++; if (cmdReady_o !== 1'b1) begin bad++; $display("FAIL rd_cmdready got=%b exp=1", cmdReady_o); end
    @(negedge clk);
    cmdValid_i = 1'b0;
    #1;
    total++; if (prfAddr_o !== a) begin bad++; $display("FAIL rd_addr got=%h exp=%h", prfAddr_o, a); end
    while (n < NB && cyc < 100) begin
      rdByteReady_i = bp ? cyc[0] : 1'b1;
      #1;
      if (rdByteValid_o) begin
        if (pend) begin
          total++; if (rdByteData_o !== held) begin bad++; $display("FAIL rd_hold[%0d] got=%h exp=%h", n, rdByteData_o, held); end
        end
        total++; if (rdByteData_o !== e[8*n +: 8]) begin bad++; $display("FAIL rd_byte[%0d] got=%h exp=%h", n, rdByteData_o, e[8*n +: 8]); end
        if (rdByteReady_i) begin n++; pend = 1'b0; end
        else begin pend = 1'b1; held = rdByteData_o; end
      end
      @(negedge clk);
      cyc++;
    end
    rdByteReady_i = 1'b0;
    #1;
    total++; if (n !== NB) begin bad++; $display("FAIL rd_count got=%0d exp=%0d", n, NB); end
    total++; if (rdByteValid_o !== 1'b0) begin bad++; $display("FAIL rd_valid_after got=%b exp=0", rdByteValid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rd_busy_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_abort_gating();
    logic [PL-1:0] a;
    logic [DW-1:0] d;
    int w0;
    a = 7'd33; d = {$urandom, $urandom}; w0 = wr_cnt;
    @(negedge clk);
    cmdValid_i = 1'b1; cmdWrite_i = 1'b1; cmdAddr_i = a;
    @(negedge clk);
    cmdValid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      byteValid_i = 1'b1; byteData_i = d[8*i +: 8];
      @(negedge clk);
    end
    byteData_i = 8'hAA;
    quiesce_i = 1'b0;
    cmdValid_i = 1'b1; cmdWrite_i = 1'b1;
    #1;
    total++; if (cmdReady_o !== 1'b0) begin bad++; $display("FAIL abort_cmdready_busy got=%b exp=0", cmdReady_o); end
    @(negedge clk);
    byteValid_i = 1'b0;
    #1;
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL abort_err got=%b exp=1", err_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    @(negedge clk);
    #1;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL abort_err_pulse got=%b exp=0", err_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cmdReady_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL gate_cycle%0d got=%b%b exp=00", i, cmdReady_o, busy_o); end
      @(negedge clk);
      #1;
    end
    total++; if (wr_cnt !== w0) begin bad++; $display("FAIL abort_no_write got=%0d exp=%0d", wr_cnt - w0, 0); end
    cmdValid_i = 1'b0;
    quiesce_i = 1'b1;
    do_read(a, 1'b0);
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    cmdValid_i = 1'b1; cmdWrite_i = 1'b0; cmdAddr_i = 7'd9;
    @(negedge clk);
    cmdValid_i = 1'b0; rdByteReady_i = 1'b0;
    cyc = 0;
    while (!rdByteValid_o && cyc < 10) begin @(negedge clk); cyc++; end
    total++; if (rdByteValid_o !== 1'b1) begin bad++; $display("FAIL ar_reach_send got=%b exp=1", rdByteValid_o); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (rdByteValid_o !== 1'b0) begin bad++; $display("FAIL ar_rdvalid got=%b exp=0", rdByteValid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy_o); end
    @(negedge clk);
    reset = 1'b0;
    do_write(7'd77, {$urandom, $urandom});
    do_read(7'd77, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      prf_mem[i] = {$urandom, $urandom};
      exp_mem[i] = prf_mem[i];
    end
    prf_mem[9] = 64'h0123456789ABCDEF;
    exp_mem[9] = 64'h0123456789ABCDEF;
    test_reset();
    do_write(7'd5, 64'h8877665544332211);
    do_read(7'd9, 1'b0);
    do_read(7'd9, 1'b1);
    do_read(7'd5, 1'b1);
    test_abort_gating();
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) do_write(7'($urandom_range(0, 127)), {$urandom, $urandom});
      else do_read(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    end
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
